// File: rtl/pc_pkg.sv
// Op encodings shared between the program counter and the control unit that drives it.
// Also holds the packed error-flag record used by pc_unit.
package pc_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_INC    = 3'b000;
    localparam logic [OP_W-1:0] OP_JUMP   = 3'b001;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'b010;
    localparam logic [OP_W-1:0] OP_CALL   = 3'b011;
    localparam logic [OP_W-1:0] OP_RET    = 3'b100;
    localparam logic [OP_W-1:0] OP_HOLD   = 3'b101;

    // 3'b110 and 3'b111 are reserved; the PC treats them as OP_INC.
    localparam logic [OP_W-1:0] OP_RSVD0  = 3'b110;
    localparam logic [OP_W-1:0] OP_RSVD1  = 3'b111;

    typedef struct packed {
        logic ovf;
        logic unf;
    } pc_err_t;

endpackage : pc_pkg

// File: rtl/pc_stack.sv
// Return-address LIFO for pc_unit. dout_o always shows the top entry from registered
// state, so a pop in the cycle right after a push returns the value just pushed.
module pc_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  entry_q [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] top_cnt;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] wr_idx;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // A push while full is only accepted when a pop frees the top slot in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign top_cnt = count_q - CW'(1);
    assign top_idx = top_cnt[IW-1:0];
    assign wr_idx  = do_pop ? top_idx : count_q[IW-1:0];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            entry_q[wr_idx] <= din_i;
        end
    end

    assign dout_o  = empty_o ? '0 : entry_q[top_idx];
    assign count_o = count_q;

endmodule : pc_stack

// File: rtl/pc_unit.sv
// Program counter with internal next-address computation: increment, jump, relative
// branch, call/return via a return-address stack, stall, and sticky stack error flags.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                 ADDR_W      = 8,
    parameter int                 STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [OP_W-1:0]                  op,
    input  logic [ADDR_W-1:0]                target,
    input  logic [ADDR_W-1:0]                offset,
    input  logic                             clear_err,
    output logic [ADDR_W-1:0]                current_address,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_branch;
    pc_err_t           err_q;
    pc_err_t           err_d;

    logic              stk_push;
    logic              stk_pop;
    logic [ADDR_W-1:0] stk_dout;
    logic [CW-1:0]     stk_count;
    logic              stk_full;
    logic              stk_empty;

    // Both sums wrap modulo 2^ADDR_W; a two's-complement offset needs no sign extension.
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign pc_branch = pc_q + offset;

    always_comb begin
        pc_d     = pc_q;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (enable) begin
            if (clear_err) begin
                err_d = '0;
            end
            // Errors are assigned after the clear so a same-cycle error keeps its flag set.
            case (op)
                OP_JUMP: begin
                    pc_d = target;
                end
                OP_BRANCH: begin
                    pc_d = pc_branch;
                end
                OP_CALL: begin
                    pc_d = target;
                    if (stk_full) begin
                        err_d.ovf = 1'b1;
                    end else begin
                        stk_push = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stk_empty) begin
                        pc_d      = pc_inc;
                        err_d.unf = 1'b1;
                    end else begin
                        pc_d    = stk_dout;
                        stk_pop = 1'b1;
                    end
                end
                OP_HOLD: begin
                    pc_d = pc_q;
                end
                default: begin
                    pc_d = pc_inc;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_ADDR;
            err_q <= '0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    pc_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .din_i   (pc_inc),
        .dout_o  (stk_dout),
        .count_o (stk_count),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    assign current_address = pc_q;
    assign stack_count     = stk_count;
    assign overflow        = err_q.ovf;
    assign underflow       = err_q.unf;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenario tasks plus a randomised run
// against a small reference model, all results flowing through one expected queue.
module tb_pc_unit;
    import pc_pkg::*;

    localparam int AW = 8;
    localparam int SD = 4;
    localparam int CW = $clog2(SD + 1);
    localparam int EW = AW + CW + 2;

    logic            clock     = 1'b0;
    logic            reset     = 1'b0;
    logic            enable    = 1'b0;
    logic [OP_W-1:0] op        = OP_INC;
    logic [AW-1:0]   target    = '0;
    logic [AW-1:0]   offset    = '0;
    logic            clear_err = 1'b0;
    logic [AW-1:0]   current_address;
    logic [CW-1:0]   stack_count;
    logic            overflow;
    logic            underflow;

    typedef struct packed {
        logic            en;
        logic            clr;
        logic [OP_W-1:0] op;
        logic [AW-1:0]   tgt;
        logic [AW-1:0]   off;
        logic [AW-1:0]   pc;
        logic [CW-1:0]   cnt;
        logic            ovf;
        logic            unf;
    } row_t;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    pc_unit #(
        .ADDR_W      (AW),
        .STACK_DEPTH (SD),
        .RESET_ADDR  (8'h00)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .op              (op),
        .target          (target),
        .offset          (offset),
        .clear_err       (clear_err),
        .current_address (current_address),
        .stack_count     (stack_count),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // driver helpers
    function automatic row_t r(input logic en, input logic clr, input logic [OP_W-1:0] o,
                               input logic [AW-1:0] t, input logic [AW-1:0] f,
                               input logic [AW-1:0] p, input logic [CW-1:0] c,
                               input logic ov, input logic un);
        row_t x;
        x.en = en; x.clr = clr; x.op = o; x.tgt = t; x.off = f;
        x.pc = p; x.cnt = c; x.ovf = ov; x.unf = un;
        return x;
    endfunction

    task automatic drive_row(input row_t x);
        enable    = x.en;
        clear_err = x.clr;
        op        = x.op;
        target    = x.tgt;
        offset    = x.off;
        exp_q.push_back({x.pc, x.cnt, x.ovf, x.unf});
    endtask

    // Called at posedge+1: drops reset half a cycle later, between clock edges.
    task automatic pulse_reset_async();
        #3;
        reset = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // scenarios
    task automatic test_reset();
        logic [EW-1:0] exp, got;
        reset  = 1'b0;
        enable = 1'b1;
        op     = OP_INC;
        exp_q.push_back({8'h00, 3'd0, 1'b0, 1'b0});
        @(posedge clock);
        #1;
        got = {current_address, stack_count, overflow, underflow};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", got, exp);
        end
        release_reset();
        for (int i = 1; i <= 3; i++) begin
            drive_row(r(1'b1, 1'b0, OP_INC, 8'h00, 8'h00, AW'(i), 3'd0, 1'b0, 1'b0));
            @(posedge clock);
            #1;
            got = {current_address, stack_count, overflow, underflow};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_inc[%0d]: got %h expected %h", i, got, exp);
            end
        end
        exp_q.push_back({8'h00, 3'd0, 1'b0, 1'b0});
        pulse_reset_async();
        got = {current_address, stack_count, overflow, underflow};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", got, exp);
        end
        release_reset();
    endtask

    task automatic test_jump();
        row_t rows[$];
        logic [EW-1:0] exp, got;
        rows.push_back(r(1'b1, 1'b0, OP_JUMP, 8'h10, 8'h00, 8'h10, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_JUMP, 8'h20, 8'h00, 8'h20, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_INC,  8'h00, 8'h00, 8'h21, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_INC,  8'h00, 8'h00, 8'h22, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_JUMP, 8'h10, 8'h00, 8'h10, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b0, 1'b0, OP_JUMP, 8'h20, 8'h00, 8'h10, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b0, 1'b1, OP_CALL, 8'h55, 8'h00, 8'h10, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_INC,  8'h00, 8'h00, 8'h11, 3'd0, 1'b0, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(posedge clock);
            #1;
            got = {current_address, stack_count, overflow, underflow};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL jump[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        logic [EW-1:0] exp, got;
        rows.push_back(r(1'b1, 1'b0, OP_JUMP,   8'h05, 8'h00, 8'h05, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_BRANCH, 8'h00, 8'hFE, 8'h03, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_BRANCH, 8'h00, 8'h03, 8'h06, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_JUMP,   8'hFF, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_INC,    8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_JUMP,   8'hF0, 8'h00, 8'hF0, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_BRANCH, 8'h00, 8'h20, 8'h10, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_RSVD0,  8'h77, 8'h00, 8'h11, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_RSVD1,  8'h77, 8'h00, 8'h12, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_HOLD,   8'h77, 8'h00, 8'h12, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_BRANCH, 8'h00, 8'h80, 8'h92, 3'd0, 1'b0, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(posedge clock);
            #1;
            got = {current_address, stack_count, overflow, underflow};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL branch[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_call_ret();
        row_t rows[$];
        logic [EW-1:0] exp, got;
        rows.push_back(r(1'b1, 1'b0, OP_JUMP, 8'h08, 8'h00, 8'h08, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_CALL, 8'h40, 8'h00, 8'h40, 3'd1, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_INC,  8'h00, 8'h00, 8'h41, 3'd1, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_INC,  8'h00, 8'h00, 8'h42, 3'd1, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_RET,  8'h00, 8'h00, 8'h09, 3'd0, 1'b0, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(posedge clock);
            #1;
            got = {current_address, stack_count, overflow, underflow};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL call_ret[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        logic [EW-1:0] exp, got;
        rows.push_back(r(1'b1, 1'b0, OP_JUMP, 8'h30, 8'h00, 8'h30, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_CALL, 8'h80, 8'h00, 8'h80, 3'd1, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_CALL, 8'h90, 8'h00, 8'h90, 3'd2, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_RET,  8'h00, 8'h00, 8'h81, 3'd1, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_RET,  8'h00, 8'h00, 8'h31, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_INC,  8'h00, 8'h00, 8'h32, 3'd0, 1'b0, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(posedge clock);
            #1;
            got = {current_address, stack_count, overflow, underflow};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_overflow();
        row_t rows[$];
        logic [EW-1:0] exp, got;
        rows.push_back(r(1'b1, 1'b0, OP_JUMP, 8'h10, 8'h00, 8'h10, 3'd0, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_CALL, 8'h20, 8'h00, 8'h20, 3'd1, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_CALL, 8'h30, 8'h00, 8'h30, 3'd2, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_CALL, 8'h40, 8'h00, 8'h40, 3'd3, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_CALL, 8'h50, 8'h00, 8'h50, 3'd4, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_CALL, 8'h60, 8'h00, 8'h60, 3'd4, 1'b1, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_RET,  8'h00, 8'h00, 8'h41, 3'd3, 1'b1, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_RET,  8'h00, 8'h00, 8'h31, 3'd2, 1'b1, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_RET,  8'h00, 8'h00, 8'h21, 3'd1, 1'b1, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_RET,  8'h00, 8'h00, 8'h11, 3'd0, 1'b1, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_RET,  8'h00, 8'h00, 8'h12, 3'd0, 1'b1, 1'b1));
        rows.push_back(r(1'b0, 1'b1, OP_INC,  8'h00, 8'h00, 8'h12, 3'd0, 1'b1, 1'b1));
        rows.push_back(r(1'b1, 1'b1, OP_INC,  8'h00, 8'h00, 8'h13, 3'd0, 1'b0, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(posedge clock);
            #1;
            got = {current_address, stack_count, overflow, underflow};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL overflow[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_flag_priority();
        row_t rows[$];
        logic [EW-1:0] exp, got;
        rows.push_back(r(1'b1, 1'b0, OP_CALL, 8'hA0, 8'h00, 8'hA0, 3'd1, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_CALL, 8'hB0, 8'h00, 8'hB0, 3'd2, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_CALL, 8'hC0, 8'h00, 8'hC0, 3'd3, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_CALL, 8'hD0, 8'h00, 8'hD0, 3'd4, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b1, OP_CALL, 8'hE0, 8'h00, 8'hE0, 3'd4, 1'b1, 1'b0));
        rows.push_back(r(1'b1, 1'b1, OP_INC,  8'h00, 8'h00, 8'hE1, 3'd4, 1'b0, 1'b0));
        rows.push_back(r(1'b1, 1'b0, OP_CALL, 8'hF0, 8'h00, 8'hF0, 3'd4, 1'b1, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(posedge clock);
            #1;
            got = {current_address, stack_count, overflow, underflow};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL flag_prio[%0d]: got %h expected %h", i, got, exp);
            end
        end
        // Reset in the middle of operation with a full stack and a set flag.
        exp_q.push_back({8'h00, 3'd0, 1'b0, 1'b0});
        pulse_reset_async();
        got = {current_address, stack_count, overflow, underflow};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL flag_prio_reset: got %h expected %h", got, exp);
        end
        release_reset();
        rows.delete();
        rows.push_back(r(1'b1, 1'b1, OP_RET,  8'h00, 8'h00, 8'h01, 3'd0, 1'b0, 1'b1));
        rows.push_back(r(1'b1, 1'b1, OP_HOLD, 8'h00, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(posedge clock);
            #1;
            got = {current_address, stack_count, overflow, underflow};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL flag_unf[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] m_pc;
        logic [AW-1:0] m_stk[$];
        logic          m_ovf, m_unf;
        logic [EW-1:0] exp, got;
        row_t          x;
        reset = 1'b0;
        #1;
        release_reset();
        m_pc  = 8'h00;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int i = 0; i < 200; i++) begin
            x.en  = ($urandom_range(0, 5) != 0);
            x.clr = ($urandom_range(0, 7) == 0);
            x.op  = OP_W'($urandom_range(0, 7));
            x.tgt = AW'($urandom_range(0, 255));
            x.off = AW'($urandom_range(0, 255));
            if (x.en) begin
                if (x.clr) begin
                    m_ovf = 1'b0;
                    m_unf = 1'b0;
                end
                case (x.op)
                    OP_JUMP:   m_pc = x.tgt;
                    OP_BRANCH: m_pc = m_pc + x.off;
                    OP_CALL: begin
                        if (m_stk.size() == SD) m_ovf = 1'b1;
                        else m_stk.push_back(m_pc + 8'h01);
                        m_pc = x.tgt;
                    end
                    OP_RET: begin
                        if (m_stk.size() == 0) begin
                            m_unf = 1'b1;
                            m_pc  = m_pc + 8'h01;
                        end else begin
                            m_pc = m_stk.pop_back();
                        end
                    end
                    OP_HOLD:   m_pc = m_pc;
                    default:   m_pc = m_pc + 8'h01;
                endcase
            end
            x.pc  = m_pc;
            x.cnt = CW'(m_stk.size());
            x.ovf = m_ovf;
            x.unf = m_unf;
            drive_row(x);
            @(posedge clock);
            #1;
            got = {current_address, stack_count, overflow, underflow};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: op=%0d en=%b got %h expected %h", i, x.op, x.en, got, exp);
            end
        end
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_jump();
        test_branch();
        test_call_ret();
        test_back_to_back();
        test_overflow();
        test_flag_priority();
        test_random();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_unit

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program counter for the processor front end.
- Successor to the plain load-only PC: it computes the next address internally instead of taking it from outside.
- Supports increment, absolute jump, PC-relative branch, subroutine call/return through an internal return-address stack, and stall.
- Sits between the control unit, which drives op/enable, and the instruction memory address port.

Parameters:
- ADDR_W, 8, width of the address, target and offset fields.
- STACK_DEPTH, 4, number of return-address entries; must be at least 1.
- RESET_ADDR, 0, value loaded into the PC on reset.

Ports:
- clock  input  1  system clock; all state updates on the posedge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = execute op this cycle; 0 = stall, all state held.
- op  input  3  operation select; encodings are in pc_pkg.
- target  input  ADDR_W  absolute destination for JUMP and CALL.
- offset  input  ADDR_W  two's-complement displacement for BRANCH.
- clear_err  input  1  clears the sticky error flags.
- current_address  output  ADDR_W  registered PC.
- stack_count  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- overflow  output  1  sticky flag: a CALL was issued with the stack full.
- underflow  output  1  sticky flag: a RET was issued with the stack empty.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-operation):
  - current_address = RESET_ADDR.
  - stack_count = 0; stack contents are don't-care.
  - overflow = 0, underflow = 0.
- Priority: reset > enable=0 > op.
- When enable=0, every register holds, including the flags. clear_err is ignored while stalled.
- Op encodings and effect at the posedge with enable=1 (P = current_address):
  - INC 3'b000: PC <= P+1.
  - JUMP 3'b001: PC <= target.
  - BRANCH 3'b010: PC <= P+offset.
  - CALL 3'b011: push P+1, then PC <= target.
  - RET 3'b100: PC <= top of stack, then pop.
  - HOLD 3'b101: PC <= P.
  - 3'b110 and 3'b111 are reserved and behave as INC.
- Arithmetic:
  - All sums are computed modulo 2^ADDR_W.
  - INC from all-ones wraps to 0.
  - BRANCH offset is sign-interpreted: offset=8'hFE at ADDR_W=8 means -2.
- Latency: one cycle. The new PC is visible on current_address after the posedge. current_address has no combinational path from any input.
- Stack:
  - LIFO. A push writes entry[stack_count] and increments stack_count. A pop reads entry[stack_count-1] and decrements it.
- CALL with stack_count == STACK_DEPTH:
  - The jump is still taken.
  - The push is dropped; existing entries and stack_count are unchanged.
  - overflow <= 1.
- RET with stack_count == 0:
  - Behaves as INC.
  - stack_count stays 0.
  - underflow <= 1.
- Flags:
  - Sticky; cleared by reset, or by clear_err=1 with enable=1.
  - If clear_err=1 and a new error occur in the same cycle, the set wins.
- Nested CALL/RET: a RET immediately after a CALL returns to the CALL address + 1, so there is no bypass hazard. The stack is read from registered state.

Decomposition:
- pc_pkg: op encoding localparams (OP_INC, OP_JUMP, OP_BRANCH, OP_CALL, OP_RET, OP_HOLD) and the OP_W=3 constant. Shared with the control unit.
- pc_stack, a sub-module: parametrised LIFO with these interfaces:
  - inputs: push, pop, din;
  - outputs: dout (top entry), count, full, empty.
  - It rejects a push when full and a pop when empty.
- pc_unit contains:
  - the next-PC mux and adder;
  - the flag logic;
  - one pc_stack instance.

Test Plan:
- Reset, then 3 INC cycles with enable=1 → current_address 0x00, 0x01, 0x02, 0x03. Asserting reset=0 mid-count → 0x00 immediately, without waiting for a clock edge.
- PC=0x10, JUMP target=0x20, then INC, then INC → 0x20, 0x21, 0x22. Repeating with enable=0 during the jump cycle → PC stays 0x10.
- PC=0x05, BRANCH offset=0xFE → 0x03. PC=0xFF, INC → 0x00. PC=0xF0, BRANCH offset=0x20 → 0x10 (wrap).
- PC=0x08, CALL target=0x40 → PC 0x40, stack_count 1. Two INCs → 0x42. RET → 0x09, stack_count 0.
- STACK_DEPTH=4: five nested CALLs → fifth jump taken, stack_count stays 4, overflow=1. Then four RETs unwind in order. A fifth RET → PC+1, underflow=1. Then clear_err → both flags 0.
- Simultaneous clear_err=1 and CALL on a full stack → overflow stays 1.
